mandala_scene_sequencer: RTL and testbench
==========================================

MANDALA_SCENE_SEQUENCER -- requirements
Module: mandala_scene_sequencer

Interface
REQ-001 SHALL have parameter SCENE_FRAMES, default 600: frames a scene is shown before auto-advance.
REQ-002 SHALL have parameter NUM_SCENES, default 5, range 1..8: number of scenes in rotation.
REQ-003 SHALL have parameter FADE_STEP_FRAMES, default 4, minimum 1: frames per brightness step.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port vsync, input, 1 bit: level vsync from the sync generator.
REQ-007 SHALL have ports btn_next and btn_pause, input, 1 bit each: raw, clk-synchronous user buttons.
REQ-008 SHALL have port auto_en, input, 1 bit: enables timed scene advance.
REQ-009 SHALL have port speed, input, 2 bits: one animation step every 2^speed frames.
REQ-010 SHALL have port scene, output, 3 bits: current scene index.
REQ-011 SHALL have port anim_phase, output, 10 bits: rotation counter for the renderer.
REQ-012 SHALL have port color_phase, output, 8 bits: palette counter for the renderer.
REQ-013 SHALL have port glitter_phase, output, 16 bits: glitter counter for the renderer.
REQ-014 SHALL have port layer_en, output, 7 bits: per-ring enable mask (bit0 = innermost ring).
REQ-015 SHALL have port brightness, output, 2 bits: global intensity, 3 = full, 0 = black.
REQ-016 SHALL have port busy, output, 1 bit: high while a scene transition is in progress.

Function
REQ-017 SHALL generate tick, a one-clk pulse one cycle after each vsync 0->1 edge; all timing below counts ticks.
REQ-018 SHALL sample both buttons on each tick; a press event is a sample of 1 whose previous sample was 0.
REQ-019 SHALL implement FSM states RUN, PAUSED, FADE_OUT, SWAP, FADE_IN; busy = 1 in FADE_OUT, SWAP and FADE_IN.
REQ-020 SHALL, in RUN, FADE_OUT and FADE_IN, count ticks in a divider; at the 2^speed-th tick, increment anim_phase, color_phase and glitter_phase by 1 each (modulo width) and clear the divider.
REQ-021 SHALL freeze all phases and the divider in PAUSED; a speed change takes effect at the next divider compare.
REQ-022 SHALL, in RUN, count ticks in frame_cnt, saturating at SCENE_FRAMES-1.
REQ-023 SHALL, in RUN, move to FADE_OUT on a next press, or on the tick where frame_cnt = SCENE_FRAMES-1 while auto_en = 1.
REQ-024 SHALL, in RUN, move to PAUSED on a pause press; if next and pause are pressed on the same tick, next wins and pause is discarded.
REQ-025 SHALL, in PAUSED, return to RUN on a pause press and move to FADE_OUT on a next press; auto-advance is inhibited.
REQ-026 SHALL, in FADE_OUT, on every FADE_STEP_FRAMES-th tick: decrement brightness if it is above 0, else move to SWAP.
REQ-027 SHALL, in SWAP (exactly one clk), perform all of the following, then enter FADE_IN:
  - set scene to (scene+1), wrapping to 0 after NUM_SCENES-1;
  - clear anim_phase and frame_cnt;
  - load layer_en from the scene table.
REQ-028 SHALL, in FADE_IN, increment brightness on every FADE_STEP_FRAMES-th tick, and enter RUN in the cycle it reaches 3.
REQ-029 SHALL ignore (not queue) button presses during FADE_OUT, SWAP and FADE_IN.
REQ-030 SHALL use the scene table 0:7F, 1:55, 2:2A, 3:0F, 4:70, 5..7:7F (hex).
REQ-031 SHALL register every output; no output is combinational from inputs.

Reset
REQ-032 SHALL, while reset = 1, force state RUN, scene 0, all phases 0, divider and frame_cnt 0, brightness 3, layer_en 7F, busy 0, button history 0.
REQ-033 SHALL, on reset asserted mid-fade, abort immediately to the REQ-032 values; the first tick after release counts as tick 1.

Structure
REQ-034 SHALL take the state encoding, the scene table and the phase widths from shared package mandala_pkg.
REQ-035 SHALL implement tick generation and button press detection in sub-module frame_event_sampler.

Verification
REQ-036 SHALL check: speed=2, 16 ticks in RUN -> anim_phase=4, color_phase=4, glitter_phase=4.
REQ-037 SHALL check: SCENE_FRAMES=8, FADE_STEP_FRAMES=1, auto_en=1 -> FADE_OUT at tick 8, brightness 2,1,0 on ticks 9-11, SWAP after tick 12, scene=1, layer_en=55, brightness 3 and busy=0 after tick 15.
REQ-038 SHALL check: pause press, 10 ticks, pause press -> phases unchanged across the pause, RUN resumes, no auto-advance while paused.
REQ-039 SHALL check: next and pause pressed on the same tick -> FADE_OUT entered, PAUSED never entered.
REQ-040 SHALL check: NUM_SCENES=5, five next-driven transitions -> scene goes 1,2,3,4,0.
REQ-041 SHALL check: reset pulse while brightness=1 in FADE_OUT -> brightness=3, scene=0, busy=0 asynchronously.

Source files
------------

// File: rtl/mandala_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mandala_pkg                                                              |
// | Shared state encoding, field widths and scene table for the sequencer.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mandala_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_PAUSED   = 3'd1,
    ST_FADE_OUT = 3'd2,
    ST_SWAP     = 3'd3,
    ST_FADE_IN  = 3'd4
  } seq_state_t;

  localparam int c_scene_w   = 3;
  localparam int c_anim_w    = 10;
  localparam int c_color_w   = 8;
  localparam int c_glitter_w = 16;
  localparam int c_layer_w   = 7;
  localparam int c_bright_w  = 2;
  localparam int c_speed_w   = 2;

  localparam logic [c_bright_w-1:0] c_bright_full = 2'd3;
  localparam logic [c_layer_w-1:0]  c_layer_all   = 7'h7F;

  // Ring enable mask shown for each scene; unused indices light every ring.
  function automatic logic [c_layer_w-1:0] scene_layers(input logic [c_scene_w-1:0] idx);
    logic [c_layer_w-1:0] mask;
    case (idx)
      3'd0:    mask = 7'h7F;
      3'd1:    mask = 7'h55;
      3'd2:    mask = 7'h2A;
      3'd3:    mask = 7'h0F;
      3'd4:    mask = 7'h70;
      default: mask = 7'h7F;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mandala_scene_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mandala_scene_sequencer_if                                               |
// | Control inputs and renderer outputs of the mandala scene sequencer.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface mandala_scene_sequencer_if;
  import mandala_pkg::*;

  logic                   vsync;
  logic                   btn_next;
  logic                   btn_pause;
  logic                   auto_en;
  logic [c_speed_w-1:0]   speed;

  logic [c_scene_w-1:0]   scene;
  logic [c_anim_w-1:0]    anim_phase;
  logic [c_color_w-1:0]   color_phase;
  logic [c_glitter_w-1:0] glitter_phase;
  logic [c_layer_w-1:0]   layer_en;
  logic [c_bright_w-1:0]  brightness;
  logic                   busy;

  modport master (
    output vsync, btn_next, btn_pause, auto_en, speed,
    input  scene, anim_phase, color_phase, glitter_phase, layer_en, brightness, busy
  );

  modport slave (
    input  vsync, btn_next, btn_pause, auto_en, speed,
    output scene, anim_phase, color_phase, glitter_phase, layer_en, brightness, busy
  );

endinterface
`default_nettype wire

// File: rtl/mandala_scene_sequencer_frame_event_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frame_event_sampler                                                      |
// | Frame tick from vsync rising edge and once-per-frame button press pulses.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module frame_event_sampler (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  input  logic btn_next,
  input  logic btn_pause,
  output logic tick,
  output logic next_press,
  output logic pause_press
);

  logic r_vsync_d;
  logic r_next_hist;
  logic r_pause_hist;
  logic w_vsync_rise;

  assign w_vsync_rise = vsync & ~r_vsync_d;

  // History starts high so a vsync held through reset does not fake a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsync_d    <= 1'b1;
      r_next_hist  <= 1'b0;
      r_pause_hist <= 1'b0;
      tick         <= 1'b0;
      next_press   <= 1'b0;
      pause_press  <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      tick      <= w_vsync_rise;
      if (w_vsync_rise) begin
        next_press   <= btn_next & ~r_next_hist;
        pause_press  <= btn_pause & ~r_pause_hist;
        r_next_hist  <= btn_next;
        r_pause_hist <= btn_pause;
      end else begin
        next_press   <= 1'b0;
        pause_press  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mandala_scene_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mandala_scene_sequencer                                                  |
// | Scene rotation, pause and fade sequencing with animation phase counters. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mandala_scene_sequencer
  import mandala_pkg::*;
#(
  parameter int SCENE_FRAMES     = 600,
  parameter int NUM_SCENES       = 5,
  parameter int FADE_STEP_FRAMES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  mandala_scene_sequencer_if.slave bus
);

  localparam int c_frame_w = (SCENE_FRAMES > 1) ? $clog2(SCENE_FRAMES) : 1;
  localparam int c_fade_w  = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam logic [c_frame_w-1:0] c_frame_last = c_frame_w'(SCENE_FRAMES - 1);
  localparam logic [c_fade_w-1:0]  c_fade_last  = c_fade_w'(FADE_STEP_FRAMES - 1);
  localparam logic [c_scene_w-1:0] c_scene_last = c_scene_w'(NUM_SCENES - 1);

  logic w_tick;
  logic w_next_press;
  logic w_pause_press;

  seq_state_t             r_state;
  logic [c_scene_w-1:0]   r_scene;
  logic [c_anim_w-1:0]    r_anim;
  logic [c_color_w-1:0]   r_color;
  logic [c_glitter_w-1:0] r_glitter;
  logic [c_layer_w-1:0]   r_layer;
  logic [c_bright_w-1:0]  r_bright;
  logic                   r_busy;
  logic [2:0]             r_div;
  logic [c_frame_w-1:0]   r_frame_cnt;
  logic [c_fade_w-1:0]    r_fade_cnt;

  logic [3:0]             w_div_next;
  logic [3:0]             w_div_limit;
  logic                   w_phase_run;
  logic                   w_div_hit;
  logic                   w_fade_hit;
  logic                   w_frame_last;
  logic [c_scene_w-1:0]   w_scene_next;

  frame_event_sampler u_sampler (
    .clk         (clk),
    .reset       (reset),
    .vsync       (bus.vsync),
    .btn_next    (bus.btn_next),
    .btn_pause   (bus.btn_pause),
    .tick        (w_tick),
    .next_press  (w_next_press),
    .pause_press (w_pause_press)
  );

  // A greater-or-equal compare lets a lowered speed take effect at once
  // even when the divider already sits past the new limit.
  always_comb begin
    w_div_next   = {1'b0, r_div} + 4'd1;
    w_div_limit  = 4'd1 << bus.speed;
    w_div_hit    = (w_div_next >= w_div_limit);
    w_phase_run  = w_tick && ((r_state == ST_RUN) || (r_state == ST_FADE_OUT) ||
                              (r_state == ST_FADE_IN));
    w_fade_hit   = (r_fade_cnt == c_fade_last);
    w_frame_last = (r_frame_cnt == c_frame_last);
    w_scene_next = (r_scene == c_scene_last) ? '0 : r_scene + 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_scene     <= '0;
      r_anim      <= '0;
      r_color     <= '0;
      r_glitter   <= '0;
      r_layer     <= c_layer_all;
      r_bright    <= c_bright_full;
      r_busy      <= 1'b0;
      r_div       <= '0;
      r_frame_cnt <= '0;
      r_fade_cnt  <= '0;
    end else begin
      if (w_phase_run) begin
        if (w_div_hit) begin
          r_div     <= '0;
          r_anim    <= r_anim + 1'b1;
          r_color   <= r_color + 1'b1;
          r_glitter <= r_glitter + 1'b1;
        end else begin
          r_div <= w_div_next[2:0];
        end
      end

      case (r_state)
        ST_RUN: begin
          if (w_tick) begin
            if (!w_frame_last) begin
              r_frame_cnt <= r_frame_cnt + c_frame_w'(1);
            end
            if (w_next_press || (bus.auto_en && w_frame_last)) begin
              r_state    <= ST_FADE_OUT;
              r_busy     <= 1'b1;
              r_fade_cnt <= '0;
            end else if (w_pause_press) begin
              r_state <= ST_PAUSED;
            end
          end
        end

        ST_PAUSED: begin
          if (w_next_press) begin
            r_state    <= ST_FADE_OUT;
            r_busy     <= 1'b1;
            r_fade_cnt <= '0;
          end else if (w_pause_press) begin
            r_state <= ST_RUN;
          end
        end

        ST_FADE_OUT: begin
          if (w_tick) begin
            if (w_fade_hit) begin
              r_fade_cnt <= '0;
              if (r_bright != '0) begin
                r_bright <= r_bright - 1'b1;
              end else begin
                r_state <= ST_SWAP;
              end
            end else begin
              r_fade_cnt <= r_fade_cnt + c_fade_w'(1);
            end
          end
        end

        ST_SWAP: begin
          r_scene     <= w_scene_next;
          r_anim      <= '0;
          r_frame_cnt <= '0;
          r_layer     <= scene_layers(w_scene_next);
          r_fade_cnt  <= '0;
          r_state     <= ST_FADE_IN;
        end

        ST_FADE_IN: begin
          if (w_tick) begin
            if (w_fade_hit) begin
              r_fade_cnt <= '0;
              r_bright   <= r_bright + 1'b1;
              // Leaving on the same edge that lands on full brightness.
              if (r_bright == 2'd2) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b0;
              end
            end else begin
              r_fade_cnt <= r_fade_cnt + c_fade_w'(1);
            end
          end
        end

        default: begin
          r_state <= ST_RUN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.scene         = r_scene;
  assign bus.anim_phase    = r_anim;
  assign bus.color_phase   = r_color;
  assign bus.glitter_phase = r_glitter;
  assign bus.layer_en      = r_layer;
  assign bus.brightness    = r_bright;
  assign bus.busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mandala_scene_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mandala_scene_sequencer                                               |
// | Two parameterisations against a frame-level behavioural model.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mandala_scene_sequencer;

  localparam int A_SF = 8,  A_NS = 5, A_FSF = 1;
  localparam int B_SF = 20, B_NS = 3, B_FSF = 3;
  localparam int M_RUN = 0, M_PAUSED = 1, M_FO = 2, M_SWAP = 3, M_FI = 4;

  typedef struct {
    int mode;
    int scene;
    int anim;
    int color;
    int glitter;
    int div;
    int frame;
    int fade;
    int bright;
    int layer;
    bit pend;
    bit pend_next;
    bit pend_pause;
    bit prev_vs;
    bit hist_n;
    bit hist_p;
  } mdl_t;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       vsync     = 1'b0;
  logic       btn_next  = 1'b0;
  logic       btn_pause = 1'b0;
  logic       auto_en   = 1'b0;
  logic [1:0] speed     = 2'd0;

  int   n_vec = 0;
  int   n_bad = 0;
  mdl_t ma;
  mdl_t mb;

  always #5 clk = ~clk;

  mandala_scene_sequencer_if bus_a ();
  mandala_scene_sequencer_if bus_b ();

  assign bus_a.vsync = vsync;     assign bus_b.vsync = vsync;
  assign bus_a.btn_next = btn_next;   assign bus_b.btn_next = btn_next;
  assign bus_a.btn_pause = btn_pause; assign bus_b.btn_pause = btn_pause;
  assign bus_a.auto_en = auto_en; assign bus_b.auto_en = auto_en;
  assign bus_a.speed = speed;     assign bus_b.speed = speed;

  mandala_scene_sequencer #(.SCENE_FRAMES(A_SF), .NUM_SCENES(A_NS), .FADE_STEP_FRAMES(A_FSF))
    dut_a (.clk(clk), .reset(rst), .bus(bus_a.slave));
  mandala_scene_sequencer #(.SCENE_FRAMES(B_SF), .NUM_SCENES(B_NS), .FADE_STEP_FRAMES(B_FSF))
    dut_b (.clk(clk), .reset(rst), .bus(bus_b.slave));

  function automatic int layer_of(input int s);
    case (s)
      0: return 'h7F;
      1: return 'h55;
      2: return 'h2A;
      3: return 'h0F;
      4: return 'h70;
      default: return 'h7F;
    endcase
  endfunction

  function automatic mdl_t mdl_init();
    mdl_t m;
    m.mode = M_RUN; m.scene = 0; m.anim = 0; m.color = 0; m.glitter = 0;
    m.div = 0; m.frame = 0; m.fade = 0; m.bright = 3; m.layer = 'h7F;
    m.pend = 0; m.pend_next = 0; m.pend_pause = 0; m.prev_vs = 1;
    m.hist_n = 0; m.hist_p = 0;
    return m;
  endfunction

  // One clock of the model: a frame event detected now is acted on next clock.
  function automatic mdl_t mdl_clock(input mdl_t m, input int sf, input int ns, input int fsf,
                                     input bit vs, input bit bn, input bit bp,
                                     input bit ae, input int spd);
    mdl_t n;
    n = m;
    n.pend = vs && !m.prev_vs;
    n.prev_vs = vs;
    n.pend_next = 0;
    n.pend_pause = 0;
    if (n.pend) begin
      n.pend_next = bn && !m.hist_n;
      n.pend_pause = bp && !m.hist_p;
      n.hist_n = bn;
      n.hist_p = bp;
    end
    if (m.mode == M_SWAP) begin
      n.scene = (m.scene + 1) % ns;
      n.anim = 0;
      n.frame = 0;
      n.fade = 0;
      n.layer = layer_of(n.scene);
      n.mode = M_FI;
    end else if (m.pend) begin
      if (m.mode != M_PAUSED) begin
        if (m.div + 1 >= (1 << spd)) begin
          n.div = 0;
          n.anim = (m.anim + 1) % 1024;
          n.color = (m.color + 1) % 256;
          n.glitter = (m.glitter + 1) % 65536;
        end else begin
          n.div = m.div + 1;
        end
      end
      case (m.mode)
        M_RUN: begin
          if (m.frame < sf - 1) n.frame = m.frame + 1;
          if (m.pend_next || (ae && m.frame == sf - 1)) begin
            n.mode = M_FO; n.fade = 0;
          end else if (m.pend_pause) begin
            n.mode = M_PAUSED;
          end
        end
        M_PAUSED: begin
          if (m.pend_next) begin
            n.mode = M_FO; n.fade = 0;
          end else if (m.pend_pause) begin
            n.mode = M_RUN;
          end
        end
        M_FO: begin
          if (m.fade + 1 == fsf) begin
            n.fade = 0;
            if (m.bright > 0) n.bright = m.bright - 1;
            else n.mode = M_SWAP;
          end else begin
            n.fade = m.fade + 1;
          end
        end
        M_FI: begin
          if (m.fade + 1 == fsf) begin
            n.fade = 0;
            n.bright = m.bright + 1;
            if (n.bright == 3) n.mode = M_RUN;
          end else begin
            n.fade = m.fade + 1;
          end
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      ma = mdl_init();
      mb = mdl_init();
    end else begin
      ma = mdl_clock(ma, A_SF, A_NS, A_FSF, vsync, btn_next, btn_pause, auto_en, int'(speed));
      mb = mdl_clock(mb, B_SF, B_NS, B_FSF, vsync, btn_next, btn_pause, auto_en, int'(speed));
    end
  end

  task automatic check_dut(input string nm, input mdl_t m, input logic [2:0] sc,
                           input logic [9:0] an, input logic [7:0] co, input logic [15:0] gl,
                           input logic [6:0] le, input logic [1:0] br, input logic bz);
    logic exp_busy;
    exp_busy = (m.mode == M_FO) || (m.mode == M_SWAP) || (m.mode == M_FI);
    n_vec++;
    if (sc !== 3'(m.scene) || an !== 10'(m.anim) || co !== 8'(m.color) ||
        gl !== 16'(m.glitter) || le !== 7'(m.layer) || br !== 2'(m.bright) || bz !== exp_busy) begin
      n_bad++;
      $display("FAIL model_%s t=%0t got/exp scene=%0d/%0d anim=%0d/%0d color=%0d/%0d glit=%0d/%0d layer=%h/%h bright=%0d/%0d busy=%0b/%0b",
               nm, $time, sc, m.scene, an, m.anim, co, m.color, gl, m.glitter,
               le, m.layer, br, m.bright, bz, exp_busy);
    end
  endtask

  initial forever begin
    @(negedge clk);
    check_dut("A", ma, bus_a.scene, bus_a.anim_phase, bus_a.color_phase, bus_a.glitter_phase,
              bus_a.layer_en, bus_a.brightness, bus_a.busy);
    check_dut("B", mb, bus_b.scene, bus_b.anim_phase, bus_b.color_phase, bus_b.glitter_phase,
              bus_b.layer_en, bus_b.brightness, bus_b.busy);
  end

  task automatic check_lit(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One video frame of len clocks with vsync high for hv clocks.
  task automatic frame(input bit bn, input bit bp, input int len, input int hv);
    @(negedge clk);
    vsync = 1'b1; btn_next = bn; btn_pause = bp;
    for (int i = 1; i < hv; i++) @(negedge clk);
    @(negedge clk);
    vsync = 1'b0;
    for (int i = hv + 1; i < len; i++) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 4, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    vsync = 1'b0; btn_next = 1'b0; btn_pause = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus_a.busy === 1'b1 && n < 40) begin
      frame(1'b0, 1'b0, 4, 1);
      n++;
    end
    check_lit({nm, "_idle"}, int'(bus_a.busy), 0);
  endtask

  task automatic run_random();
    int len, hv;
    bit bn, bp;
    for (int f = 0; f < 2500; f++) begin
      len = $urandom_range(7, 3);
      hv  = $urandom_range(2, 1);
      bn  = ($urandom_range(11, 0) == 0);
      bp  = ($urandom_range(9, 0) == 0);
      if ($urandom_range(39, 0) == 0) auto_en = ~auto_en;
      if ($urandom_range(29, 0) == 0) speed = 2'($urandom_range(3, 0));
      if ($urandom_range(499, 0) == 0) do_reset();
      frame(bn, bp, len, hv);
    end
  endtask

  initial begin
    int rec, n;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    check_lit("rst_scene", int'(bus_a.scene), 0);
    check_lit("rst_bright", int'(bus_a.brightness), 3);
    check_lit("rst_layer", int'(bus_a.layer_en), 'h7F);
    check_lit("rst_busy", int'(bus_a.busy), 0);
    check_lit("rst_anim", int'(bus_a.anim_phase), 0);

    // Divider: one step every fourth frame.
    auto_en = 1'b0; speed = 2'd2;
    frames(16);
    check_lit("div_anim", int'(bus_a.anim_phase), 4);
    check_lit("div_color", int'(bus_a.color_phase), 4);
    check_lit("div_glitter", int'(bus_a.glitter_phase), 4);
    check_lit("model_anim_pin", ma.anim, 4);

    // Auto-advance timeline.
    do_reset();
    auto_en = 1'b1; speed = 2'd0;
    for (int t = 1; t <= 15; t++) begin
      frame(1'b0, 1'b0, 4, 1);
      case (t)
        7:  check_lit("auto_t7_busy", int'(bus_a.busy), 0);
        8:  begin
              check_lit("auto_t8_busy", int'(bus_a.busy), 1);
              check_lit("auto_t8_bright", int'(bus_a.brightness), 3);
            end
        9:  check_lit("auto_t9_bright", int'(bus_a.brightness), 2);
        10: check_lit("auto_t10_bright", int'(bus_a.brightness), 1);
        11: check_lit("auto_t11_bright", int'(bus_a.brightness), 0);
        12: begin
              check_lit("auto_t12_scene", int'(bus_a.scene), 1);
              check_lit("auto_t12_layer", int'(bus_a.layer_en), 'h55);
              check_lit("auto_t12_anim", int'(bus_a.anim_phase), 0);
            end
        14: check_lit("auto_t14_bright", int'(bus_a.brightness), 2);
        15: begin
              check_lit("auto_t15_bright", int'(bus_a.brightness), 3);
              check_lit("auto_t15_busy", int'(bus_a.busy), 0);
              check_lit("model_scene_pin", ma.scene, 1);
            end
        default: ;
      endcase
    end

    // Pause holds phases and inhibits auto-advance.
    do_reset();
    auto_en = 1'b1; speed = 2'd0;
    frame(1'b0, 1'b1, 4, 1);
    check_lit("pause_anim0", int'(bus_a.anim_phase), 1);
    frames(10);
    check_lit("pause_anim10", int'(bus_a.anim_phase), 1);
    check_lit("pause_glit10", int'(bus_a.glitter_phase), 1);
    check_lit("pause_scene", int'(bus_a.scene), 0);
    check_lit("pause_busy", int'(bus_a.busy), 0);
    frame(1'b0, 1'b1, 4, 1);
    check_lit("unpause_anim", int'(bus_a.anim_phase), 1);
    frame(1'b0, 1'b0, 4, 1);
    check_lit("resume_anim", int'(bus_a.anim_phase), 2);

    // Simultaneous next and pause: next wins.
    do_reset();
    auto_en = 1'b0; speed = 2'd0;
    frame(1'b1, 1'b1, 4, 1);
    check_lit("both_busy", int'(bus_a.busy), 1);
    frame(1'b0, 1'b0, 4, 1);
    check_lit("both_bright", int'(bus_a.brightness), 2);
    wait_idle("both");
    check_lit("both_scene", int'(bus_a.scene), 1);
    rec = int'(bus_a.anim_phase);
    frame(1'b0, 1'b0, 4, 1);
    check_lit("both_running", int'(bus_a.anim_phase), rec + 1);

    // Five next-driven transitions wrap the rotation.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      frame(1'b1, 1'b0, 4, 1);
      wait_idle("next");
      check_lit($sformatf("next_scene_%0d", k), int'(bus_a.scene), k % 5);
    end

    // Asynchronous reset in the middle of a fade-out.
    frame(1'b1, 1'b0, 4, 1);
    wait_idle("pre_rst");
    check_lit("pre_rst_scene", int'(bus_a.scene), 1);
    frame(1'b1, 1'b0, 4, 1);
    n = 0;
    while (bus_a.brightness !== 2'd1 && n < 8) begin
      frame(1'b0, 1'b0, 4, 1);
      n++;
    end
    check_lit("fade_bright1", int'(bus_a.brightness), 1);
    #2 rst = 1'b1;
    #1;
    check_lit("async_bright", int'(bus_a.brightness), 3);
    check_lit("async_scene", int'(bus_a.scene), 0);
    check_lit("async_busy", int'(bus_a.busy), 0);
    check_lit("async_layer", int'(bus_a.layer_en), 'h7F);
    @(negedge clk);
    #2 rst = 1'b0;

    run_random();

    frames(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: stimulus did not complete, got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
